// File: rtl/if_stage_pkg.sv
// Shared core definitions for the instruction-fetch stage: the word type,
// the NOP encoding and the default reset vector.
package if_stage_pkg;

  typedef logic [31:0] word_t;

  // addi x0, x0, 0
  localparam word_t NOP_INSTR = 32'h0000_0013;

  localparam word_t RESET_PC_DEFAULT = 32'h0000_0000;

  // One buffered fetch result: where it came from and what was read.
  typedef struct packed {
    word_t pc;
    word_t instr;
  } fetch_entry_t;

endpackage

// File: rtl/if_stage_fetch_skid_fifo.sv
// Two-entry skid buffer of {pc, instr} fetch results.
// The caller guarantees pop only when non-empty and push only when not full
// (or when popping in the same cycle). Flush empties the buffer and wins
// over push and pop. Storage is not reset; only the pointers and count are.
module fetch_skid_fifo
  import if_stage_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  fetch_entry_t push_data,
  input  logic         pop,
  input  logic         flush,
  output fetch_entry_t head,
  output logic         full,
  output logic         empty,
  output logic [1:0]   count
);

  fetch_entry_t mem [2];
  logic         rd_ptr;
  logic         wr_ptr;
  logic [1:0]   cnt;

  // Pointer and occupancy bookkeeping; flush behaves like reset.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      cnt    <= 2'd0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      cnt <= cnt + {1'b0, push} - {1'b0, pop};
    end
  end

  // Entry storage, written on push.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= push_data;
  end

  assign head  = mem[rd_ptr];
  assign full  = (cnt == 2'd2);
  assign empty = (cnt == 2'd0);
  assign count = cnt;

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage. Issues one word fetch per cycle to a ROM with a
// fixed one-cycle read latency, tags the outstanding fetch with its address,
// and delivers {pc, instr} to decode. Results that decode cannot take yet
// are parked in a two-entry skid buffer; issue is throttled so the buffer
// can always absorb the response already in flight. A redirect flushes
// everything and restarts at the target; a misaligned target parks the stage
// in a sticky fault until the next redirect or reset.
module if_stage
  import if_stage_pkg::*;
#(
  parameter word_t RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] rom_addr,
  output logic        rom_rd,
  input  logic [31:0] rom_data,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        stall,
  output logic [31:0] instr,
  output logic [31:0] pc,
  output logic        valid,
  output logic        fetch_fault
);

  // Stage p0: fetch PC / issue. Stage p1: ROM response in flight.
  word_t        fetch_pc_p0;
  logic         vld_p1;
  word_t        pc_p1;
  logic         fault;

  fetch_entry_t resp;
  fetch_entry_t head;
  fetch_entry_t out_entry;
  logic         full;
  logic         empty;
  logic [1:0]   count;
  logic         out_vld;
  logic         accept;
  logic         pop;
  logic         push;
  logic [1:0]   occ;
  logic         issue;

  assign resp = '{pc: pc_p1, instr: rom_data};

  // Output select, buffer push/pop and fetch-issue throttle.
  always_comb begin
    out_vld   = 1'b0;
    out_entry = resp;
    if (!empty) begin
      out_vld   = 1'b1;
      out_entry = head;
    end else begin
      out_vld   = vld_p1;
      out_entry = resp;
    end
    accept = out_vld & ~stall;
    pop    = ~empty & accept;
    // A response taken straight from the bypass does not need buffering.
    push   = vld_p1 & ~(empty & accept) & (~full | pop);
    // Entries left after this cycle's pop plus the response still due.
    occ    = count - {1'b0, pop} + {1'b0, vld_p1};
    issue  = ~redirect & ~fault & (occ < 2'd2);
  end

  // p0 -> p1 boundary: fetch PC, in-flight flag and sticky fault.
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc_p0 <= RESET_PC;
      vld_p1      <= 1'b0;
      fault       <= 1'b0;
    end else if (redirect) begin
      fetch_pc_p0 <= redirect_pc;
      vld_p1      <= 1'b0;
      fault       <= (redirect_pc[1:0] != 2'b00);
    end else begin
      vld_p1 <= issue;
      if (issue) fetch_pc_p0 <= fetch_pc_p0 + 32'd4;
    end
  end

  // Address tag for the in-flight fetch.
  always_ff @(posedge clk) begin
    if (issue) pc_p1 <= fetch_pc_p0;
  end

  fetch_skid_fifo u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (resp),
    .pop       (pop),
    .flush     (redirect),
    .head      (head),
    .full      (full),
    .empty     (empty),
    .count     (count)
  );

  assign rom_addr    = fetch_pc_p0;
  assign rom_rd      = issue & ~reset;
  assign valid       = out_vld & ~reset;
  assign pc          = valid ? out_entry.pc : 32'h0000_0000;
  assign instr       = valid ? out_entry.instr : NOP_INSTR;
  assign fetch_fault = fault & ~reset;

endmodule

// File: tb/tb_if_stage.sv
module tb_if_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        redirect;
  logic        stall;
  logic [31:0] redirect_pc;

  logic [31:0] rom_addr0, rom_data0, instr0, pc0;
  logic        rom_rd0, valid0, fault0;
  logic [31:0] rom_addr1, rom_data1, instr1, pc1;
  logic        rom_rd1, valid1, fault1;

  localparam logic [31:0] NOPW = 32'h0000_0013;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  if_stage #(.RESET_PC(32'h0000_0000)) dut0 (
    .clk(clk), .reset(reset), .rom_addr(rom_addr0), .rom_rd(rom_rd0),
    .rom_data(rom_data0), .redirect(redirect), .redirect_pc(redirect_pc),
    .stall(stall), .instr(instr0), .pc(pc0), .valid(valid0),
    .fetch_fault(fault0)
  );

  if_stage #(.RESET_PC(32'hFFFF_FFF8)) dut1 (
    .clk(clk), .reset(reset), .rom_addr(rom_addr1), .rom_rd(rom_rd1),
    .rom_data(rom_data1), .redirect(redirect), .redirect_pc(redirect_pc),
    .stall(stall), .instr(instr1), .pc(pc1), .valid(valid1),
    .fetch_fault(fault1)
  );

  // ROM models: word i holds value i; garbage when no read was issued.
  always @(posedge clk) begin
    rom_data0 <= rom_rd0 ? (rom_addr0 >> 2) : 32'hDEAD_BEEF;
    rom_data1 <= rom_rd1 ? (rom_addr1 >> 2) : 32'hDEAD_BEEF;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench just after the edge that starts cycle 0 (reset low).
  task automatic do_reset();
    reset = 1'b1; redirect = 1'b0; stall = 1'b0; redirect_pc = 32'h0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; redirect = 1'b0; stall = 1'b0; redirect_pc = 32'h0;
    tick();
    tick();
    @(negedge clk);
    n_total++;
    if ({valid0, rom_rd0, fault0, pc0, instr0} !== {3'b000, 32'h0, NOPW}) begin
      $display("FAIL reset_dut0: got v=%b rd=%b f=%b pc=%h instr=%h want 0 0 0 0 %h",
               valid0, rom_rd0, fault0, pc0, instr0, NOPW);
    end else n_pass++;
    n_total++;
    if ({valid1, rom_rd1, fault1, pc1, instr1} !== {3'b000, 32'h0, NOPW}) begin
      $display("FAIL reset_dut1: got v=%b rd=%b f=%b pc=%h instr=%h want 0 0 0 0 %h",
               valid1, rom_rd1, fault1, pc1, instr1, NOPW);
    end else n_pass++;
  endtask

  task automatic test_stream();
    logic [31:0] ep;
    do_reset();
    for (int c = 0; c < 8; c++) begin
      if (c > 0) tick();
      @(negedge clk);
      n_total++;
      if ({rom_rd0, rom_addr0} !== {1'b1, 32'(4 * c)}) begin
        $display("FAIL stream_fetch c%0d: got rd=%b addr=%h want 1 %h",
                 c, rom_rd0, rom_addr0, 32'(4 * c));
      end else n_pass++;
      if (c == 0) begin
        n_total++;
        if ({valid0, instr0} !== {1'b0, NOPW}) begin
          $display("FAIL stream_first_idle: got v=%b instr=%h want 0 %h", valid0, instr0, NOPW);
        end else n_pass++;
      end else begin
        ep = 32'(4 * (c - 1));
        n_total++;
        if ({valid0, pc0, instr0} !== {1'b1, ep, ep >> 2}) begin
          $display("FAIL stream_out c%0d: got v=%b pc=%h instr=%h want 1 %h %h",
                   c, valid0, pc0, instr0, ep, ep >> 2);
        end else n_pass++;
        if (c < 5) begin
          ep = 32'hFFFF_FFF8 + 32'(4 * (c - 1));
          n_total++;
          if ({valid1, pc1, instr1} !== {1'b1, ep, ep >> 2}) begin
            $display("FAIL wrap_out c%0d: got v=%b pc=%h instr=%h want 1 %h %h",
                     c, valid1, pc1, instr1, ep, ep >> 2);
          end else n_pass++;
        end
      end
    end
  endtask

  task automatic test_stall();
    logic [31:0] ep [10] = '{32'h0, 32'h0, 32'h4, 32'h8, 32'h8, 32'h8, 32'h8,
                             32'hC, 32'h10, 32'h14};
    logic [9:0]  erd = 10'b11_1100_1111;
    do_reset();
    for (int c = 0; c < 10; c++) begin
      if (c > 0) tick();
      stall = (c >= 3 && c <= 5);
      @(negedge clk);
      n_total++;
      if (rom_rd0 !== erd[c]) begin
        $display("FAIL stall_rd c%0d: got %b want %b", c, rom_rd0, erd[c]);
      end else n_pass++;
      if (c >= 1) begin
        n_total++;
        if ({valid0, pc0, instr0} !== {1'b1, ep[c], ep[c] >> 2}) begin
          $display("FAIL stall_out c%0d: got v=%b pc=%h instr=%h want 1 %h %h",
                   c, valid0, pc0, instr0, ep[c], ep[c] >> 2);
        end else n_pass++;
      end
    end
    stall = 1'b0;
  endtask

  task automatic test_redirect_full();
    do_reset();
    redirect_pc = 32'h100;
    for (int c = 0; c < 9; c++) begin
      if (c > 0) tick();
      stall    = (c == 3 || c == 4);
      redirect = (c == 5);
      @(negedge clk);
      if (c == 5) begin
        n_total++;
        if ({valid0, pc0, rom_rd0} !== {1'b1, 32'h8, 1'b0}) begin
          $display("FAIL redir_cycle: got v=%b pc=%h rd=%b want 1 00000008 0",
                   valid0, pc0, rom_rd0);
        end else n_pass++;
      end
      if (c == 6) begin
        n_total++;
        if ({valid0, instr0, rom_rd0, rom_addr0} !== {1'b0, NOPW, 1'b1, 32'h100}) begin
          $display("FAIL redir_bubble: got v=%b instr=%h rd=%b addr=%h want 0 %h 1 00000100",
                   valid0, instr0, rom_rd0, rom_addr0, NOPW);
        end else n_pass++;
      end
      if (c == 7) begin
        n_total++;
        if ({valid0, pc0, instr0} !== {1'b1, 32'h100, 32'h40}) begin
          $display("FAIL redir_target: got v=%b pc=%h instr=%h want 1 00000100 00000040",
                   valid0, pc0, instr0);
        end else n_pass++;
      end
      if (c == 8) begin
        n_total++;
        if ({valid0, pc0, instr0} !== {1'b1, 32'h104, 32'h41}) begin
          $display("FAIL redir_next: got v=%b pc=%h instr=%h want 1 00000104 00000041",
                   valid0, pc0, instr0);
        end else n_pass++;
      end
    end
    redirect = 1'b0;
    stall    = 1'b0;
  endtask

  task automatic test_redirect_stall();
    logic [31:0] ep [8] = '{32'h0, 32'h0, 32'h0, 32'h8, 32'h0, 32'h40, 32'h40, 32'h44};
    logic [7:0]  ev = 8'b1110_1110;
    do_reset();
    redirect_pc = 32'h40;
    for (int c = 0; c < 8; c++) begin
      if (c > 0) tick();
      redirect = (c == 3);
      stall    = (c >= 3 && c <= 5);
      @(negedge clk);
      if (c >= 3) begin
        n_total++;
        if ({valid0, pc0, instr0} !== {ev[c], ep[c], ev[c] ? (ep[c] >> 2) : NOPW}) begin
          $display("FAIL rstall_out c%0d: got v=%b pc=%h instr=%h want %b %h",
                   c, valid0, pc0, instr0, ev[c], ep[c]);
        end else n_pass++;
      end
      if (c == 4) begin
        n_total++;
        if ({rom_rd0, rom_addr0} !== {1'b1, 32'h40}) begin
          $display("FAIL rstall_fetch: got rd=%b addr=%h want 1 00000040", rom_rd0, rom_addr0);
        end else n_pass++;
      end
    end
    redirect = 1'b0;
    stall    = 1'b0;
  endtask

  task automatic test_fault();
    do_reset();
    for (int c = 0; c < 9; c++) begin
      if (c > 0) tick();
      redirect    = (c == 2 || c == 6);
      redirect_pc = (c == 6) ? 32'h200 : 32'h102;
      @(negedge clk);
      if (c >= 3 && c <= 6) begin
        n_total++;
        if ({fault0, rom_rd0, valid0, instr0} !== {3'b100, NOPW}) begin
          $display("FAIL fault_hold c%0d: got f=%b rd=%b v=%b instr=%h want 1 0 0 %h",
                   c, fault0, rom_rd0, valid0, instr0, NOPW);
        end else n_pass++;
      end
      if (c == 7) begin
        n_total++;
        if ({fault0, valid0, rom_rd0, rom_addr0} !== {3'b001, 32'h200}) begin
          $display("FAIL fault_clear: got f=%b v=%b rd=%b addr=%h want 0 0 1 00000200",
                   fault0, valid0, rom_rd0, rom_addr0);
        end else n_pass++;
      end
      if (c == 8) begin
        n_total++;
        if ({fault0, valid0, pc0, instr0} !== {2'b01, 32'h200, 32'h80}) begin
          $display("FAIL fault_resume: got f=%b v=%b pc=%h instr=%h want 0 1 00000200 00000080",
                   fault0, valid0, pc0, instr0);
        end else n_pass++;
      end
    end
    redirect = 1'b0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int c = 0; c < 7; c++) begin
      if (c > 0) tick();
      reset = (c == 4);
      @(negedge clk);
      if (c == 4) begin
        n_total++;
        if ({valid0, rom_rd0, fault0, pc0, instr0} !== {3'b000, 32'h0, NOPW}) begin
          $display("FAIL midreset_out: got v=%b rd=%b f=%b pc=%h instr=%h want 0 0 0 0 %h",
                   valid0, rom_rd0, fault0, pc0, instr0, NOPW);
        end else n_pass++;
      end
      if (c == 5) begin
        n_total++;
        if ({valid0, rom_rd0, rom_addr0} !== {2'b01, 32'h0}) begin
          $display("FAIL midreset_restart: got v=%b rd=%b addr=%h want 0 1 00000000",
                   valid0, rom_rd0, rom_addr0);
        end else n_pass++;
      end
      if (c == 6) begin
        n_total++;
        if ({valid0, pc0, instr0} !== {1'b1, 32'h0, 32'h0}) begin
          $display("FAIL midreset_first: got v=%b pc=%h instr=%h want 1 0 0",
                   valid0, pc0, instr0);
        end else n_pass++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_redirect_full();
    test_redirect_stall();
    test_fault();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
